// File: rtl/gtx_tx_arbiter.sv
// Round-robin arbiter that streams one channel's frame RAM onto a 16-bit GTX lane,
// inserting a K character (16'h50BC) every 16 cycles and slot-numbered filler words when idle.
module gtx_tx_arbiter (
  input  logic        DataSendCLK,
  input  logic        RST,
  input  logic [3:0]  Req_i,
  input  logic [59:0] Len_i,
  input  logic [15:0] RdData_i,
  output logic [3:0]  Grant_o,
  output logic        RdEn_o,
  output logic [16:0] RdAddr_o,
  output logic [3:0]  Done_o,
  output logic        Busy_o,
  output logic [15:0] DataSend,
  output logic        DataSendisK,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  slot;
  logic [1:0]  sel;
  logic [1:0]  last;
  logic [16:0] total;
  logic [16:0] addr;
  logic        rd_en_q;
  logic [1:0]  pick;
  logic [1:0]  cand;
  logic        pick_vld;
  logic [14:0] len_sel;
  logic        issue;

  // RAM read handshake: a cycle with RdEn_o=1 presents RdAddr_o, and the RAM must return
  // that word on RdData_i during the following cycle; there is no back-pressure.
  assign issue = (state == SEND) && (slot != 4'd15) && (total != 17'd0);

  // Round-robin search starting just above the last served channel.
  always_comb begin
    pick     = last;
    cand     = 2'd0;
    pick_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!pick_vld && Req_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    len_sel = Len_i[14:0];
    case (pick)
      2'd0: len_sel = Len_i[14:0];
      2'd1: len_sel = Len_i[29:15];
      2'd2: len_sel = Len_i[44:30];
      2'd3: len_sel = Len_i[59:45];
      default: len_sel = Len_i[14:0];
    endcase
  end

  always_ff @(posedge DataSendCLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_vld) state_nxt = SEND;
      SEND: if ((total == 17'd0) || (issue && (addr == total - 17'd1))) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant stays up through DONE so the final returned word is still muxed from the right RAM.
  always_comb begin
    Grant_o   = 4'b0000;
    Done_o    = 4'b0000;
    Busy_o    = (state != IDLE);
    RdEn_o    = issue;
    RdAddr_o  = addr;
    dbg_state = state;
    if (state != IDLE) Grant_o = 4'b0001 << sel;
    if (state == DONE) Done_o = 4'b0001 << sel;
  end

  always_ff @(posedge DataSendCLK) begin
    if (RST) begin
      slot        <= 4'd0;
      sel         <= 2'd0;
      last        <= 2'd3;
      total       <= 17'd0;
      addr        <= 17'd0;
      rd_en_q     <= 1'b0;
      DataSend    <= 16'h0000;
      DataSendisK <= 1'b0;
    end else begin
      slot    <= slot + 4'd1;
      rd_en_q <= issue;
      if ((state == IDLE) && pick_vld) begin
        sel   <= pick;
        total <= {len_sel, 2'b00};
        addr  <= 17'd0;
      end
      if (issue) addr <= addr + 17'd1;
      if (state == DONE) last <= sel;
      // Slot 15 never reads, so returned data can never land on the K slot.
      if (slot == 4'd0) begin
        DataSend    <= 16'h50BC;
        DataSendisK <= 1'b1;
      end else if (rd_en_q) begin
        DataSend    <= RdData_i;
        DataSendisK <= 1'b0;
      end else begin
        DataSend    <= {12'h000, slot};
        DataSendisK <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gtx_tx_arbiter.sv
// Self-checking bench for gtx_tx_arbiter: RAM model, lane/stream scoreboard and
// scenario tasks checked against a round-robin reference model.
module tb_gtx_tx_arbiter;

  logic        DataSendCLK;
  logic        RST;
  logic [3:0]  Req_i;
  logic [59:0] Len_i;
  logic [15:0] RdData_i;
  logic [3:0]  Grant_o;
  logic        RdEn_o;
  logic [16:0] RdAddr_o;
  logic [3:0]  Done_o;
  logic        Busy_o;
  logic [15:0] DataSend;
  logic        DataSendisK;
  logic [1:0]  dbg_state;

  gtx_tx_arbiter dut (
    .DataSendCLK (DataSendCLK),
    .RST         (RST),
    .Req_i       (Req_i),
    .Len_i       (Len_i),
    .RdData_i    (RdData_i),
    .Grant_o     (Grant_o),
    .RdEn_o      (RdEn_o),
    .RdAddr_o    (RdAddr_o),
    .Done_o      (Done_o),
    .Busy_o      (Busy_o),
    .DataSend    (DataSend),
    .DataSendisK (DataSendisK),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    DataSendCLK = 1'b0;
    forever #5 DataSendCLK = ~DataSendCLK;
  end

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model state ----------------
  logic [15:0] mem [4][512];
  logic [14:0] len_m [4];
  int          last_m = 3;

  int          grant_log[$];
  int          rdcnt_log[$];
  logic [3:0]  done_log[$];
  logic [15:0] exp_q[$];

  logic [3:0]  slot_m    = 4'd0;
  logic [3:0]  slot_prev = 4'd0;
  bit          rst_prev  = 1'b1;
  bit          rd_d1     = 1'b0;
  bit          rd_d2     = 1'b0;
  int          frame_rd  = 0;
  int          cur_ch    = 0;
  logic [3:0]  grant_prev = 4'b0000;
  logic [3:0]  done_prev  = 4'b0000;
  logic [15:0] rd_next    = 16'h0000;

  function automatic int rr_pick(input int last, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  // RAM model: word for a read seen in cycle c is presented during cycle c+1.
  initial begin
    RdData_i = 16'h0000;
    forever begin
      @(posedge DataSendCLK);
      #1;
      RdData_i = rd_next;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge DataSendCLK) begin
    logic [15:0] exp_d;
    logic        exp_k;
    logic [15:0] d;
    int          gch;
    if (rst_prev) begin
      slot_m = 4'd0;
      exp_d  = 16'h0000;
      exp_k  = 1'b0;
      exp_q.delete();
      rd_d1  = 1'b0;
      rd_d2  = 1'b0;
    end else begin
      d = 16'h0000;
      if (rd_d2 && exp_q.size() > 0) d = exp_q.pop_front();
      if (slot_prev == 4'd0) begin
        exp_d = 16'h50BC;
        exp_k = 1'b1;
      end else if (rd_d2) begin
        exp_d = d;
        exp_k = 1'b0;
      end else begin
        exp_d = {12'h000, slot_prev};
        exp_k = 1'b0;
      end
      slot_m = slot_prev + 4'd1;
    end
    checks++;
    if (DataSend !== exp_d || DataSendisK !== exp_k) begin
      failures++;
      $display("FAIL ds_stream t=%0t got %h/k%b expected %h/k%b", $time, DataSend, DataSendisK, exp_d, exp_k);
    end
    rd_d2 = rd_d1;
    rd_d1 = 1'b0;

    if (grant_prev == 4'b0000 && Grant_o != 4'b0000 && !RST) begin
      checks++;
      if (done_prev != 4'b0000) begin
        failures++;
        $display("FAIL frame_gap t=%0t grant %b came right after done %b", $time, Grant_o, done_prev);
      end
      cur_ch = oh_idx(Grant_o);
      if (cur_ch < 0) cur_ch = 0;
      grant_log.push_back(oh_idx(Grant_o));
      frame_rd = 0;
    end

    if (RdEn_o === 1'b1) begin
      checks++;
      if (slot_m == 4'd15) begin
        failures++;
        $display("FAIL rden_k_slot t=%0t read issued in slot 15", $time);
      end
      checks++;
      if (RdAddr_o !== 17'(frame_rd)) begin
        failures++;
        $display("FAIL rd_addr t=%0t got %0d expected %0d", $time, RdAddr_o, frame_rd);
      end
      gch = oh_idx(Grant_o);
      checks++;
      if (gch < 0) begin
        failures++;
        $display("FAIL rd_grant t=%0t read with grant %b", $time, Grant_o);
        gch = 0;
      end
      rd_next = mem[gch][RdAddr_o[8:0]];
      exp_q.push_back(mem[cur_ch][frame_rd % 512]);
      rd_d1 = 1'b1;
      frame_rd++;
    end else begin
      rd_next = 16'($urandom);
    end

    if (Done_o != 4'b0000) begin
      checks++;
      if (Done_o !== Grant_o) begin
        failures++;
        $display("FAIL done_grant t=%0t done %b grant %b", $time, Done_o, Grant_o);
      end
      done_log.push_back(Done_o);
      rdcnt_log.push_back(frame_rd);
    end

    rst_prev   = RST;
    slot_prev  = slot_m;
    grant_prev = Grant_o;
    done_prev  = Done_o;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge DataSendCLK);
    #1;
  endtask

  task automatic apply_len();
    Len_i = {len_m[3], len_m[2], len_m[1], len_m[0]};
  endtask

  task automatic do_reset();
    Req_i = 4'b0000;
    RST   = 1'b1;
    tick(2);
    RST    = 1'b0;
    last_m = 3;
  endtask

  task automatic wait_grants(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (grant_log.size() >= n) begin
        ok = 1'b1;
        return;
      end
      tick(1);
    end
  endtask

  task automatic wait_dones(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_log.size() >= n) begin
        ok = 1'b1;
        return;
      end
      tick(1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST   = 1'b1;
    Req_i = 4'b0000;
    for (int c = 0; c < 4; c++) len_m[c] = 15'd0;
    apply_len();
    tick(3);
    checks++;
    if (Grant_o !== 4'b0000 || Done_o !== 4'b0000 || RdEn_o !== 1'b0 || Busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl grant=%b done=%b rden=%b busy=%b expected all zero", Grant_o, Done_o, RdEn_o, Busy_o);
    end
    checks++;
    if (RdAddr_o !== 17'd0) begin
      failures++;
      $display("FAIL reset_addr got %0d expected 0", RdAddr_o);
    end
    checks++;
    if (DataSend !== 16'h0000 || DataSendisK !== 1'b0) begin
      failures++;
      $display("FAIL reset_lane got %h/k%b expected 0000/k0", DataSend, DataSendisK);
    end
    RST = 1'b0;
    tick(1);
    checks++;
    if (DataSend !== 16'h50BC || DataSendisK !== 1'b1) begin
      failures++;
      $display("FAIL first_k got %h/k%b expected 50bc/k1", DataSend, DataSendisK);
    end
  endtask

  task automatic test_idle();
    int kcnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (DataSendisK === 1'b1) kcnt++;
      checks++;
      if (Grant_o !== 4'b0000 || Busy_o !== 1'b0) begin
        failures++;
        $display("FAIL idle_grant got grant=%b busy=%b expected 0000/0", Grant_o, Busy_o);
      end
    end
    checks++;
    if (kcnt != 2) begin
      failures++;
      $display("FAIL idle_kcount got %0d expected 2", kcnt);
    end
  endtask

  task automatic run_frame(input string name, input logic [3:0] req, input int budget);
    bit ok;
    int exp_ch;
    int exp_rd;
    int g0 = grant_log.size();
    int d0 = done_log.size();
    Req_i = req;
    wait_grants(g0 + 1, 20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_grant_timeout req=%b", name, req);
      Req_i = 4'b0000;
      return;
    end
    Req_i  = 4'b0000;
    exp_ch = rr_pick(last_m, req);
    exp_rd = 4 * int'(len_m[exp_ch]);
    last_m = exp_ch;
    // Length must be latched at grant: scramble it mid-frame.
    for (int c = 0; c < 4; c++) len_m[c] = 15'($urandom_range(0, 6));
    apply_len();
    if (grant_log[g0] != exp_ch) begin
      failures++;
      $display("FAIL %s_grant got %0d expected %0d", name, grant_log[g0], exp_ch);
    end
    wait_dones(d0 + 1, budget, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_done_timeout", name);
      return;
    end
    checks++;
    if (done_log[d0] !== (4'b0001 << exp_ch)) begin
      failures++;
      $display("FAIL %s_done got %b expected %b", name, done_log[d0], 4'b0001 << exp_ch);
    end
    checks++;
    if (rdcnt_log[d0] != exp_rd) begin
      failures++;
      $display("FAIL %s_reads got %0d expected %0d", name, rdcnt_log[d0], exp_rd);
    end
  endtask

  task automatic test_single();
    len_m[0] = 15'd1;
    apply_len();
    run_frame("single", 4'b0001, 40);
    tick(1);
    checks++;
    if (Done_o !== 4'b0000) begin
      failures++;
      $display("FAIL single_done_width got %b expected 0000", Done_o);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int g0;
    int d0;
    int exp_ch;
    do_reset();
    for (int c = 0; c < 4; c++) len_m[c] = 15'd2;
    apply_len();
    g0 = grant_log.size();
    d0 = done_log.size();
    Req_i = 4'b1111;
    wait_grants(g0 + 5, 200, ok);
    Req_i = 4'b0000;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_timeout grants=%0d expected %0d", grant_log.size() - g0, 5);
      return;
    end
    wait_dones(d0 + 5, 60, ok);
    for (int i = 0; i < 5; i++) begin
      exp_ch = rr_pick(last_m, 4'b1111);
      last_m = exp_ch;
      checks++;
      if (grant_log[g0 + i] != exp_ch) begin
        failures++;
        $display("FAIL rr_order[%0d] got %0d expected %0d", i, grant_log[g0 + i], exp_ch);
      end
      checks++;
      if (!ok || rdcnt_log[d0 + i] != 8) begin
        failures++;
        $display("FAIL rr_reads[%0d] got %0d expected 8", i, ok ? rdcnt_log[d0 + i] : -1);
      end
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    int g0;
    int d0;
    do_reset();
    len_m[2] = 15'd0;
    len_m[3] = 15'd1;
    apply_len();
    g0 = grant_log.size();
    d0 = done_log.size();
    Req_i = 4'b1100;
    wait_grants(g0 + 2, 60, ok);
    Req_i = 4'b0000;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL zero_timeout grants=%0d expected 2", grant_log.size() - g0);
      return;
    end
    wait_dones(d0 + 2, 40, ok);
    checks++;
    if (!ok || grant_log[g0] != 2 || grant_log[g0 + 1] != 3) begin
      failures++;
      $display("FAIL zero_order got %0d,%0d expected 2,3", grant_log[g0], grant_log[g0 + 1]);
    end
    checks++;
    if (!ok || rdcnt_log[d0] != 0 || rdcnt_log[d0 + 1] != 4) begin
      failures++;
      $display("FAIL zero_reads got %0d,%0d expected 0,4", ok ? rdcnt_log[d0] : -1, ok ? rdcnt_log[d0 + 1] : -1);
    end
    last_m = 3;
  endtask

  task automatic test_long();
    len_m[1] = 15'd8;
    apply_len();
    run_frame("long", 4'b0010, 120);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < 4; c++) len_m[c] = 15'($urandom_range(0, 6));
      apply_len();
      run_frame("rand", 4'($urandom_range(1, 15)), 80);
      tick($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int g0;
    int d0;
    len_m[0] = 15'd100;
    apply_len();
    g0 = grant_log.size();
    Req_i = 4'b0001;
    wait_grants(g0 + 1, 20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrst_grant_timeout");
      Req_i = 4'b0000;
      return;
    end
    tick(20);
    d0 = done_log.size();
    RST = 1'b1;
    tick(1);
    checks++;
    if (Grant_o !== 4'b0000 || Busy_o !== 1'b0 || RdEn_o !== 1'b0) begin
      failures++;
      $display("FAIL midrst_abort grant=%b busy=%b rden=%b expected 0000/0/0", Grant_o, Busy_o, RdEn_o);
    end
    RST    = 1'b0;
    last_m = 3;
    for (int c = 0; c < 4; c++) len_m[c] = 15'd1;
    apply_len();
    g0 = grant_log.size();
    Req_i = 4'b1111;
    wait_grants(g0 + 1, 20, ok);
    Req_i = 4'b0000;
    checks++;
    if (!ok || grant_log[g0] != 0) begin
      failures++;
      $display("FAIL midrst_first_grant got %0d expected 0", ok ? grant_log[g0] : -1);
    end
    checks++;
    if (done_log.size() != d0) begin
      failures++;
      $display("FAIL midrst_no_done got %0d pulses expected 0", done_log.size() - d0);
    end
    wait_dones(d0 + 1, 40, ok);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    RST   = 1'b1;
    Req_i = 4'b0000;
    Len_i = 60'd0;
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < 512; a++) mem[c][a] = 16'($urandom);
    end
    test_reset();
    test_idle();
    test_single();
    test_round_robin();
    test_zero_len();
    test_long();
    test_random();
    test_reset_mid();
    tick(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
